// File: rtl/tmr_pkg.sv
// Shared types for the TMR supervisor: campaign FSM states and fault-injection target codes.
package tmr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_INJECT = 2'd2,
        ST_DONE   = 2'd3
    } tmr_state_e;

    localparam logic [1:0] TGT_A    = 2'd0;
    localparam logic [1:0] TGT_B    = 2'd1;
    localparam logic [1:0] TGT_C    = 2'd2;
    localparam logic [1:0] TGT_NONE = 2'd3;

    // One-hot injection mask for a target code; TGT_NONE yields no injection.
    function automatic logic [2:0] tgt_mask(input logic [1:0] tgt);
        logic [2:0] m;
        case (tgt)
            TGT_A:   m = 3'b001;
            TGT_B:   m = 3'b010;
            TGT_C:   m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tmr_majority.sv
// Bitwise 2-of-3 voter with per-core disagreement flags and a no-majority indicator.
module tmr_majority #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] v,
    output logic [2:0]   dis,
    output logic         all_diff
);

    assign v        = (a & b) | (a & c) | (b & c);
    assign dis      = {(c != v), (b != v), (a != v)};
    // Whole-field disagreement between every pair means no core can be trusted.
    assign all_diff = (a != b) && (b != c) && (a != c);

endmodule

// File: rtl/tmr_fault_ctrl.sv
// Lockstep supervisor for three replicated cores: votes memory-facing buses, tracks
// disagreements and runs a single-target fault-injection campaign.
module tmr_fault_ctrl
    import tmr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] pc_a,
    input  logic [DATA_W-1:0] pc_b,
    input  logic [DATA_W-1:0] pc_c,
    input  logic [DATA_W-1:0] alu_a,
    input  logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [DATA_W-1:0] rd2_a,
    input  logic [DATA_W-1:0] rd2_b,
    input  logic [DATA_W-1:0] rd2_c,
    input  logic              mw_a,
    input  logic              mw_b,
    input  logic              mw_c,
    input  logic              cfg_start,
    input  logic [1:0]        cfg_target,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_len,
    output logic [DATA_W-1:0] pc_v,
    output logic [DATA_W-1:0] alu_v,
    output logic [DATA_W-1:0] rd2_v,
    output logic              mw_v,
    output logic [2:0]        inject_error,
    output logic [2:0]        mismatch,
    output logic              fatal,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              busy,
    output logic              done
);

    logic [2:0] dis_pc_s, dis_alu_s, dis_rd2_s, dis_mw_s, dis_s;
    logic       nd_pc_s, nd_alu_s, nd_rd2_s, nd_mw_s;

    tmr_majority #(.W(DATA_W)) u_vote_pc  (.a(pc_a),  .b(pc_b),  .c(pc_c),  .v(pc_v),  .dis(dis_pc_s),  .all_diff(nd_pc_s));
    tmr_majority #(.W(DATA_W)) u_vote_alu (.a(alu_a), .b(alu_b), .c(alu_c), .v(alu_v), .dis(dis_alu_s), .all_diff(nd_alu_s));
    tmr_majority #(.W(DATA_W)) u_vote_rd2 (.a(rd2_a), .b(rd2_b), .c(rd2_c), .v(rd2_v), .dis(dis_rd2_s), .all_diff(nd_rd2_s));
    tmr_majority #(.W(1))      u_vote_mw  (.a(mw_a),  .b(mw_b),  .c(mw_c),  .v(mw_v),  .dis(dis_mw_s),  .all_diff(nd_mw_s));

    assign dis_s = dis_pc_s | dis_alu_s | dis_rd2_s | dis_mw_s;

    tmr_state_e       state_q, state_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [2:0]       inject_q, inject_d;
    logic [2:0]       mismatch_q;
    logic             fatal_q;
    logic [CNT_W-1:0] err_q;
    logic             busy_q, done_q;

    // Campaign next-state: a zero delay or zero length skips the corresponding phase.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        delay_d = delay_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    tgt_d   = cfg_target;
                    delay_d = cfg_delay;
                    len_d   = cfg_len;
                    if (cfg_delay != {CNT_W{1'b0}}) begin
                        state_d = ST_WAIT;
                    end else if (cfg_len != {CNT_W{1'b0}}) begin
                        state_d = ST_INJECT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (delay_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = (len_q != {CNT_W{1'b0}}) ? ST_INJECT : ST_DONE;
                end else begin
                    delay_d = delay_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_INJECT: begin
                if (len_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = ST_DONE;
                end else begin
                    len_d = len_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        inject_d = (state_d == ST_INJECT) ? tgt_mask(tgt_d) : 3'b000;
    end

    // State, counters and all registered status outputs; reset overrides every update.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            tgt_q      <= TGT_NONE;
            delay_q    <= {CNT_W{1'b0}};
            len_q      <= {CNT_W{1'b0}};
            inject_q   <= 3'b000;
            mismatch_q <= 3'b000;
            fatal_q    <= 1'b0;
            err_q      <= {CNT_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            delay_q    <= delay_d;
            len_q      <= len_d;
            inject_q   <= inject_d;
            mismatch_q <= dis_s;
            fatal_q    <= fatal_q | nd_pc_s | nd_alu_s | nd_rd2_s | nd_mw_s;
            if ((dis_s != 3'b000) && (err_q != {CNT_W{1'b1}})) begin
                err_q <= err_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_q <= err_q;
            end
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign inject_error = inject_q;
    assign mismatch     = mismatch_q;
    assign fatal        = fatal_q;
    assign err_cnt      = err_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
